// File: rtl/alu_issue_unit.sv
`timescale 1ns/1ps
// Instruction-side sequencer for the combinational MIPS alu: fetches operands from a
// local register file, drives the alu, then post-processes result/flags and writes back.
module alu_issue_unit #(
    parameter int          NREGS       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    input  logic        pre_we,
    input  logic [4:0]  pre_addr,
    input  logic [31:0] pre_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        branch_taken,
    output logic        ovf_trap,
    output logic        bad_op
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t      state;
    logic [31:0] instr_q;
    logic [31:0] result_q;
    logic [2:0]  flags_q;
    logic [31:0] regs [NREGS];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data;
    logic        dec_we, dec_trap, dec_bad, dec_br, is_slt, can_trap, rf_wr;
    logic [4:0]  dec_addr;
    logic [31:0] dec_data;

    // R0 and addresses beyond the file depth read as zero and ignore writes
    function automatic logic live_reg(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREGS);
    endfunction

    assign op    = instr_q[31:26];
    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign rd    = instr_q[15:11];
    assign funct = instr_q[5:0];

    assign rs_data     = live_reg(rs) ? regs[rs] : '0;
    assign rt_data     = live_reg(rt) ? regs[rt] : '0;
    assign dbg_data    = live_reg(dbg_addr) ? regs[dbg_addr] : '0;
    assign instr_ready = (state == IDLE);

    always_comb begin
        dec_we   = 1'b0;
        dec_bad  = 1'b0;
        dec_br   = 1'b0;
        dec_trap = 1'b0;
        is_slt   = 1'b0;
        can_trap = 1'b0;
        dec_addr = rt;
        dec_data = result_q;
        case (op)
            6'h00: begin
                dec_addr = rd;
                case (funct)
                    6'h20, 6'h22: begin dec_we = 1'b1; can_trap = 1'b1; end
                    6'h2A, 6'h2B: begin dec_we = 1'b1; is_slt = 1'b1; end
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: dec_we = 1'b1;
                    default: dec_bad = 1'b1;
                endcase
            end
            6'h08:                      begin dec_we = 1'b1; can_trap = 1'b1; end
            6'h0A, 6'h0B:               begin dec_we = 1'b1; is_slt = 1'b1; end
            6'h09, 6'h0C, 6'h0D, 6'h0E: dec_we = 1'b1;
            6'h23, 6'h2B:               dec_we = 1'b0;
            6'h04, 6'h05:               dec_br = flags_q[2];
            default:                    dec_bad = 1'b1;
        endcase
        if (is_slt)
            dec_data = {31'b0, flags_q[1]};
        if (can_trap && flags_q[0]) begin
            dec_we   = 1'b0;
            dec_trap = 1'b1;
        end
    end

    assign rf_wr = (state == WB) && dec_we && live_reg(dec_addr);

    // Writeback is ordered after preload so it wins an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= RESET_VALUE;
        end else begin
            if (pre_we && live_reg(pre_addr))
                regs[pre_addr] <= pre_data;
            if (rf_wr)
                regs[dec_addr] <= dec_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            instr_q         <= '0;
            result_q        <= '0;
            flags_q         <= '0;
            alu_instruction <= '0;
            alu_regA        <= '0;
            alu_regB        <= '0;
            wb_valid        <= 1'b0;
            wb_we           <= 1'b0;
            wb_addr         <= '0;
            wb_data         <= '0;
            branch_taken    <= 1'b0;
            ovf_trap        <= 1'b0;
            bad_op          <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    instr_q <= instr;
                    state   <= READ;
                end
                READ: begin
                    alu_instruction <= instr_q;
                    alu_regA        <= rs_data;
                    alu_regB        <= rt_data;
                    state           <= EXEC;
                end
                EXEC: begin
                    result_q <= alu_result;
                    flags_q  <= alu_flags;
                    state    <= WB;
                end
                WB: begin
                    wb_valid     <= 1'b1;
                    wb_we        <= dec_we;
                    wb_addr      <= dec_addr;
                    wb_data      <= dec_data;
                    branch_taken <= dec_br;
                    ovf_trap     <= dec_trap;
                    bad_op       <= dec_bad;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
`timescale 1ns/1ps
// Bench for alu_issue_unit: behavioural alu stand-in plus an architectural model of the
// register file and writeback rules, driven by directed and random instructions.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] alu_instruction, alu_regA, alu_regB, alu_result;
    logic [2:0]  alu_flags;
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        wb_valid, wb_we, branch_taken, ovf_trap, bad_op;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_regs [32];

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        trap;
        logic        bad;
        logic        br;
        logic        is_br;
        logic        chk_data;
    } exp_t;

    alu_issue_unit dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_instruction(alu_instruction), .alu_regA(alu_regA),
        .alu_regB(alu_regB), .alu_result(alu_result), .alu_flags(alu_flags),
        .pre_we(pre_we), .pre_addr(pre_addr), .pre_data(pre_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .branch_taken(branch_taken),
        .ovf_trap(ovf_trap), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    // Stand-in for the MIPS alu: returns {zero, negative, overflow, result}
    function automatic logic [34:0] alu_eval(input logic [31:0] w, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r, se, ze;
        logic        z, n, v;
        se = {{16{w[15]}}, w[15:0]};
        ze = {16'b0, w[15:0]};
        r = '0; v = 1'b0;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
                6'h22: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
                6'h21: r = a + b;
                6'h23, 6'h2A, 6'h2B: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h00: r = b << w[10:6];
                6'h02: r = b >> w[10:6];
                6'h03: r = $signed(b) >>> w[10:6];
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: r = $signed(b) >>> a[4:0];
                default: r = '0;
            endcase
            6'h08: begin r = a + se; v = (a[31] == se[31]) && (r[31] != a[31]); end
            6'h09, 6'h23, 6'h2B: r = a + se;
            6'h0A, 6'h0B: r = a - se;
            6'h0C: r = a & ze;
            6'h0D: r = a | ze;
            6'h0E: r = a ^ ze;
            6'h04, 6'h05: r = a - b;
            default: r = '0;
        endcase
        z = (r == 32'd0);
        n = r[31];
        if (w[31:26] == 6'h00 && w[5:0] == 6'h2A) n = $signed(a) < $signed(b);
        if (w[31:26] == 6'h00 && w[5:0] == 6'h2B) n = a < b;
        if (w[31:26] == 6'h0A) n = $signed(a) < $signed(se);
        if (w[31:26] == 6'h0B) n = a < se;
        if (w[31:26] == 6'h04) z = (a == b);
        if (w[31:26] == 6'h05) z = (a != b);
        return {z, n, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_eval(alu_instruction, alu_regA, alu_regB);

    // Architectural expectation of one instruction against the current model registers
    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        logic [5:0]  op, fn;
        logic [31:0] a, b, se;
        longint      sa, sb, ssum;
        logic        can_ovf;
        op = w[31:26]; fn = w[5:0];
        a  = ref_regs[w[25:21]];
        b  = ref_regs[w[20:16]];
        se = {{16{w[15]}}, w[15:0]};
        sa = $signed(a); sb = $signed(b);
        ssum = 0; can_ovf = 1'b0;
        e = '0;
        e.addr = w[20:16];
        e.data = alu_eval(w, a, b) & 35'h0_FFFF_FFFF;
        if (op == 6'h00) begin
            e.addr = w[15:11];
            if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
                e.we = 1'b1; e.chk_data = 1'b1;
            end else
                e.bad = 1'b1;
            if (fn == 6'h2A) e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            if (fn == 6'h2B) e.data = (a < b) ? 32'd1 : 32'd0;
            if (fn == 6'h20) begin ssum = sa + sb; can_ovf = 1'b1; end
            if (fn == 6'h22) begin ssum = sa - sb; can_ovf = 1'b1; end
        end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E}) begin
            e.we = 1'b1; e.chk_data = 1'b1;
            if (op == 6'h0A) e.data = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            if (op == 6'h0B) e.data = (a < se) ? 32'd1 : 32'd0;
            if (op == 6'h08) begin ssum = sa + longint'($signed(se)); can_ovf = 1'b1; end
        end else if (op == 6'h23 || op == 6'h2B) begin
            e.data = a + se; e.chk_data = 1'b1;
        end else if (op == 6'h04 || op == 6'h05) begin
            e.is_br = 1'b1;
            e.br = (op == 6'h04) ? (a == b) : (a != b);
        end else
            e.bad = 1'b1;
        if (can_ovf && (ssum > 64'sh7FFF_FFFF || ssum < -64'sh8000_0000)) begin
            e.we = 1'b0; e.trap = 1'b1; e.chk_data = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
        if (a != 5'd0) ref_regs[a] = d;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1 chk(tag, dbg_data, exp);
    endtask

    task automatic run_instr(input logic [31:0] w);
        exp_t e;
        int   cyc;
        e = model(w);
        @(negedge clk);
        chk("ready_idle", 32'(instr_ready), 32'd1);
        instr = w; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        cyc = 0;
        while (wb_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd4);
        if (wb_valid === 1'b1) begin
            chk("wb_we", 32'(wb_we), 32'(e.we));
            chk("ovf_trap", 32'(ovf_trap), 32'(e.trap));
            chk("bad_op", 32'(bad_op), 32'(e.bad));
            if (!e.bad && !e.is_br) chk("wb_addr", 32'(wb_addr), 32'(e.addr));
            if (e.chk_data) chk("wb_data", wb_data, e.data);
            if (e.is_br) chk("branch_taken", 32'(branch_taken), 32'(e.br));
        end
        if (e.we && e.addr != 5'd0) ref_regs[e.addr] = e.data;
        peek("regfile", e.addr, ref_regs[e.addr]);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [5:0] fn_pool [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    logic [5:0] op_pool [15] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};

    initial begin
        logic [31:0] w, d;
        logic [5:0]  op;
        foreach (ref_regs[i]) ref_regs[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_alu_instruction", alu_instruction, 32'd0);
        chk("rst_alu_regA", alu_regA, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_flags", {27'b0, wb_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: add, overflow trap, addu wrap
        preload(5'd1, 32'd1);
        preload(5'd2, 32'd1);
        run_instr(rtype(6'h20, 5'd1, 5'd2, 5'd3, 5'd0));
        peek("add_r3", 5'd3, 32'd2);
        preload(5'd1, 32'h7FFF_FFFF);
        preload(5'd2, 32'h7FFF_FFFF);
        run_instr(rtype(6'h20, 5'd1, 5'd2, 5'd3, 5'd0));
        peek("trap_r3_kept", 5'd3, 32'd2);
        run_instr(rtype(6'h21, 5'd1, 5'd2, 5'd3, 5'd0));
        peek("addu_r3", 5'd3, 32'hFFFF_FFFE);

        // slt vs sltu
        preload(5'd1, 32'hFFFF_0000);
        preload(5'd2, 32'h0000_FFFF);
        run_instr(rtype(6'h2A, 5'd1, 5'd2, 5'd4, 5'd0));
        peek("slt_r4", 5'd4, 32'd1);
        run_instr(rtype(6'h2B, 5'd1, 5'd2, 5'd5, 5'd0));
        peek("sltu_r5", 5'd5, 32'd0);

        // Branches
        preload(5'd2, 32'hFFFF_0000);
        run_instr(itype(6'h04, 5'd1, 5'd2, 16'h0010));
        preload(5'd1, 32'd0);
        run_instr(itype(6'h04, 5'd1, 5'd2, 16'h0010));

        // Continuous instr_valid: one accept per four cycles
        preload(5'd1, 32'd9);
        preload(5'd2, 32'd5);
        w = rtype(6'h21, 5'd1, 5'd2, 5'd6, 5'd0);
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            chk("thr_ready", 32'(instr_ready), 32'((k % 4) == 0));
            chk("thr_wb_valid", 32'(wb_valid), 32'((k % 4) == 0 && k > 0));
        end
        instr_valid = 1'b0;
        ref_regs[6] = 32'd14;
        peek("thr_r6", 5'd6, 32'd14);

        // Reset while an instruction is in EXEC
        preload(5'd1, 32'd3);
        preload(5'd2, 32'd4);
        @(negedge clk);
        instr = rtype(6'h21, 5'd1, 5'd2, 5'd7, 5'd0); instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_ready", 32'(instr_ready), 32'd1);
        chk("rst_exec_alu_instr", alu_instruction, 32'd0);
        chk("rst_exec_alu_regB", alu_regB, 32'd0);
        peek("rst_exec_r1", 5'd1, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_wb", 32'(wb_valid), 32'd0);
        end
        foreach (ref_regs[i]) ref_regs[i] = '0;
        peek("rst_r7", 5'd7, 32'd0);

        // Unsupported opcode and R0 behaviour
        run_instr(itype(6'h3F, 5'd1, 5'd2, 16'h1234));
        preload(5'd0, 32'd5);
        peek("r0_zero", 5'd0, 32'd0);
        run_instr(itype(6'h09, 5'd0, 5'd0, 16'h0055));

        // Randomized instruction stream with interleaved preloads
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: d = 32'h7FFF_FFFF;
                    1: d = 32'h8000_0000;
                    default: d = $urandom;
                endcase
                preload(5'($urandom_range(0, 7)), d);
            end
            op = op_pool[$urandom_range(0, 14)];
            if (op == 6'h00)
                w = rtype(fn_pool[$urandom_range(0, 16)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
            else
                w = itype(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          16'($urandom));
            run_instr(w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
